// File: rtl/modulo_dispensador_rolhas_pkg.sv
// Shared definitions for the cork dispenser: FSM state encoding and default sizing.
package modulo_dispensador_rolhas_pkg;

  typedef enum logic [1:0] {
    OCIOSO    = 2'b00,
    CALCULA   = 2'b01,
    TRANSFERE = 2'b10,
    CONCLUI   = 2'b11
  } estado_t;

  localparam int LARG_PAD        = 7;
  localparam int MAX_RESERVA_PAD = 99;
  localparam int LOTE_PAD        = 20;

endpackage

// File: rtl/modulo_dispensador_rolhas_min3.sv
// Combinational minimum of three unsigned values, built from a less-than comparator.
module modulo_min3_7bits #(
  parameter int LARG = 7
) (
  input  logic [LARG-1:0] a,
  input  logic [LARG-1:0] b,
  input  logic [LARG-1:0] c,
  output logic [LARG-1:0] minimo
);

  function automatic logic menor(input logic [LARG-1:0] x, input logic [LARG-1:0] y);
    return x < y;
  endfunction

  logic [LARG-1:0] min_ab;

  // Two cascaded compare/select stages
  always_comb begin
    min_ab = menor(a, b) ? a : b;
    minimo = menor(c, min_ab) ? c : min_ab;
  end

endmodule

// File: rtl/modulo_dispensador_rolhas.sv
// Cork reserve dispenser: answers transfer requests with one-cycle cork pulses,
// then acknowledges; accepts saturating operator refills at any time.
module modulo_dispensador_rolhas
  import modulo_dispensador_rolhas_pkg::*;
#(
  parameter int LARG_RESERVA = LARG_PAD,
  parameter int MAX_RESERVA  = MAX_RESERVA_PAD,
  parameter int LOTE         = LOTE_PAD
) (
  input  logic                    clk,
  input  logic                    Nclr,
  input  logic                    req_transfer,
  input  logic [LARG_RESERVA-1:0] espaco_princ,
  input  logic                    carga_operador,
  input  logic [LARG_RESERVA-1:0] valor_carga,
  output logic                    ack_transfer,
  output logic                    pulso_rolha,
  output logic [LARG_RESERVA-1:0] qtd_lote,
  output logic [LARG_RESERVA-1:0] reserva,
  output logic                    reserva_vazia,
  output logic                    erro_carga,
  output logic                    ocupado
);

  estado_t               estado;
  logic [LARG_RESERVA-1:0] espaco_lat;
  logic [LARG_RESERVA-1:0] restante;
  logic [LARG_RESERVA-1:0] minimo;
  logic [LARG_RESERVA:0]   soma;

  modulo_min3_7bits #(
    .LARG(LARG_RESERVA)
  ) u_min3 (
    .a      (LARG_RESERVA'(LOTE)),
    .b      (reserva),
    .c      (espaco_lat),
    .minimo (minimo)
  );

  // Next reserve in one extra bit: refill in, dispensed cork out
  always_comb begin
    soma = {1'b0, reserva} - {{LARG_RESERVA{1'b0}}, pulso_rolha};
    if (carga_operador)
      soma = soma + {1'b0, valor_carga};
  end

  // Reserve register with saturation at capacity and overflow flag
  always_ff @(posedge clk) begin
    if (!Nclr) begin
      reserva    <= '0;
      erro_carga <= 1'b0;
    end else if (soma > (LARG_RESERVA+1)'(MAX_RESERVA)) begin
      reserva    <= LARG_RESERVA'(MAX_RESERVA);
      erro_carga <= 1'b1;
    end else begin
      reserva    <= soma[LARG_RESERVA-1:0];
      erro_carga <= 1'b0;
    end
  end

  // Handshake FSM; pulse and ack are registered alongside the state transition
  always_ff @(posedge clk) begin
    if (!Nclr) begin
      estado       <= OCIOSO;
      espaco_lat   <= '0;
      restante     <= '0;
      qtd_lote     <= '0;
      pulso_rolha  <= 1'b0;
      ack_transfer <= 1'b0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (req_transfer) begin
            estado     <= CALCULA;
            espaco_lat <= espaco_princ;
          end
        end
        CALCULA: begin
          qtd_lote <= minimo;
          restante <= minimo;
          if (minimo == '0) begin
            estado       <= CONCLUI;
            ack_transfer <= 1'b1;
          end else begin
            estado      <= TRANSFERE;
            pulso_rolha <= 1'b1;
          end
        end
        TRANSFERE: begin
          // The cork of this cycle is counted even when the request is withdrawn
          restante <= restante - 1'b1;
          if (!req_transfer) begin
            estado      <= OCIOSO;
            pulso_rolha <= 1'b0;
          end else if (restante == LARG_RESERVA'(1)) begin
            estado       <= CONCLUI;
            pulso_rolha  <= 1'b0;
            ack_transfer <= 1'b1;
          end
        end
        CONCLUI: begin
          if (!req_transfer) begin
            estado       <= OCIOSO;
            ack_transfer <= 1'b0;
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

  assign reserva_vazia = (reserva == '0);
  assign ocupado       = (estado != OCIOSO);

endmodule

// File: tb/tb_modulo_dispensador_rolhas.sv
// Directed bench for the cork dispenser handshake and reserve arithmetic.
module tb_modulo_dispensador_rolhas;

  logic       clk = 1'b0;
  logic       Nclr;
  logic       req_transfer;
  logic [6:0] espaco_princ;
  logic       carga_operador;
  logic [6:0] valor_carga;
  logic       ack_transfer;
  logic       pulso_rolha;
  logic [6:0] qtd_lote;
  logic [6:0] reserva;
  logic       reserva_vazia;
  logic       erro_carga;
  logic       ocupado;

  int n_comp = 0;
  int n_erro = 0;

  modulo_dispensador_rolhas dut (
    .clk            (clk),
    .Nclr           (Nclr),
    .req_transfer   (req_transfer),
    .espaco_princ   (espaco_princ),
    .carga_operador (carga_operador),
    .valor_carga    (valor_carga),
    .ack_transfer   (ack_transfer),
    .pulso_rolha    (pulso_rolha),
    .qtd_lote       (qtd_lote),
    .reserva        (reserva),
    .reserva_vazia  (reserva_vazia),
    .erro_carga     (erro_carga),
    .ocupado        (ocupado)
  );

  always #5 clk = ~clk;

  task automatic verifica(input string tag, input int obs, input int esp);
    n_comp++;
    if (obs != esp) begin
      n_erro++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs until ack (or timeout), counting pulses and the tick index of the first one
  task automatic espera_ack(output int pulsos, output int primeiro, output int ciclos);
    bit feito;
    pulsos = 0; primeiro = 0; ciclos = 0; feito = 0;
    for (int i = 1; i <= 60 && !feito; i++) begin
      tick();
      if (pulso_rolha) begin
        if (pulsos == 0) primeiro = i;
        pulsos++;
      end
      if (ack_transfer) begin
        ciclos = i;
        feito  = 1;
      end
    end
    if (!feito) verifica("timeout_ack", 0, 1);
  endtask

  task automatic recarga(input int v);
    carga_operador = 1'b1;
    valor_carga    = 7'(v);
    tick();
    carga_operador = 1'b0;
    valor_carga    = '0;
  endtask

  task automatic reinicia();
    Nclr = 1'b0;
    tick();
    Nclr = 1'b1;
  endtask

  task automatic verifica_reset(input string tag);
    verifica({tag, "_reserva"}, reserva, 0);
    verifica({tag, "_vazia"},   reserva_vazia, 1);
    verifica({tag, "_qtd"},     qtd_lote, 0);
    verifica({tag, "_pulso"},   pulso_rolha, 0);
    verifica({tag, "_ack"},     ack_transfer, 0);
    verifica({tag, "_erro"},    erro_carga, 0);
    verifica({tag, "_ocupado"}, ocupado, 0);
  endtask

  int p, f, c;

  initial begin
    Nclr = 1'b0; req_transfer = 1'b0; espaco_princ = '0;
    carga_operador = 1'b0; valor_carga = '0;
    tick(); tick();
    verifica_reset("rst");
    Nclr = 1'b1;

    // Full batch of 20 from 50
    recarga(50);
    verifica("carga50", reserva, 50);
    espaco_princ = 7'd99; req_transfer = 1'b1;
    espera_ack(p, f, c);
    verifica("b20_pulsos", p, 20);
    verifica("b20_primeiro", f, 2);
    verifica("b20_qtd", qtd_lote, 20);
    verifica("b20_reserva", reserva, 30);
    tick(); tick(); tick();
    verifica("b20_hold_ack", ack_transfer, 1);
    verifica("b20_hold_pulso", pulso_rolha, 0);
    verifica("b20_hold_reserva", reserva, 30);
    req_transfer = 1'b0;
    tick();
    verifica("b20_ack_off", ack_transfer, 0);
    verifica("b20_ocioso", ocupado, 0);

    // Batch bounded by reserve
    reinicia();
    recarga(7);
    req_transfer = 1'b1;
    espera_ack(p, f, c);
    verifica("b7_pulsos", p, 7);
    verifica("b7_qtd", qtd_lote, 7);
    verifica("b7_reserva", reserva, 0);
    verifica("b7_vazia", reserva_vazia, 1);
    req_transfer = 1'b0;
    tick();

    // Empty reserve: immediate ack
    req_transfer = 1'b1;
    tick();
    verifica("b0_calcula_ocupado", ocupado, 1);
    verifica("b0_calcula_ack", ack_transfer, 0);
    tick();
    verifica("b0_ack", ack_transfer, 1);
    verifica("b0_qtd", qtd_lote, 0);
    verifica("b0_pulso", pulso_rolha, 0);
    req_transfer = 1'b0;
    tick();

    // Refill saturation
    recarga(90);
    verifica("sat_90", reserva, 90);
    verifica("sat_90_erro", erro_carga, 0);
    recarga(20);
    verifica("sat_99", reserva, 99);
    verifica("sat_erro", erro_carga, 1);
    tick();
    verifica("sat_erro_1ciclo", erro_carga, 0);
    verifica("sat_hold", reserva, 99);

    // Refill netted against a dispensed cork
    reinicia();
    recarga(40);
    req_transfer = 1'b1;
    tick(); tick();
    verifica("mix_pulso", pulso_rolha, 1);
    verifica("mix_antes", reserva, 40);
    recarga(5);
    verifica("mix_44", reserva, 44);
    espera_ack(p, f, c);
    verifica("mix_fim", reserva, 25);
    verifica("mix_qtd", qtd_lote, 20);
    req_transfer = 1'b0;
    tick();

    // Request withdrawn during third pulse
    req_transfer = 1'b1;
    p = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (pulso_rolha) p++;
    end
    req_transfer = 1'b0;
    tick();
    if (pulso_rolha) p++;
    verifica("abort_pulsos", p, 3);
    verifica("abort_reserva", reserva, 22);
    verifica("abort_ocupado", ocupado, 0);
    tick(); tick();
    verifica("abort_ack", ack_transfer, 0);
    verifica("abort_pulso", pulso_rolha, 0);

    // Batch bounded by latched free space (input changed after sampling)
    espaco_princ = 7'd5; req_transfer = 1'b1;
    tick();
    espaco_princ = 7'd99;
    espera_ack(p, f, c);
    verifica("esp5_pulsos", p, 5);
    verifica("esp5_qtd", qtd_lote, 5);
    verifica("esp5_reserva", reserva, 17);
    req_transfer = 1'b0;
    tick();

    // Reset in the middle of a transfer
    req_transfer = 1'b1;
    tick(); tick(); tick();
    verifica("mid_pulso", pulso_rolha, 1);
    Nclr = 1'b0;
    tick();
    verifica_reset("mid_rst");
    Nclr = 1'b1; req_transfer = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_erro);
    $finish;
  end

endmodule
